// File: rtl/wb_frame_memory.sv
// -----------------------------------------------------------------------------
// wb_frame_memory
//   Wishbone classic slave frame-buffer memory. Sits at the far end of the VGA
//   controller's video-memory master port and holds pixel words in on-chip
//   RAM. Every access is answered after a fixed number of wait states. A
//   consecutive-address (CAB) burst whose next request follows its ACK
//   immediately skips those wait states. Addresses outside the mapped window
//   terminate with ERR_O and never touch the RAM.
//
// Parameters
//   ADDR_W       log2 of RAM depth in 32-bit words (DEPTH = 2**ADDR_W, < 30)
//   BASE_WORD    first word address (ADR_I units) mapped to RAM word 0
//   WAIT_CYCLES  wait states before ACK on a non-burst access (0..15)
//
// Ports
//   clk    system clock, everything on the rising edge
//   rst    synchronous reset, active low
//   CYC_I  bus cycle in progress
//   STB_I  transfer request strobe
//   WE_I   1 = write, 0 = read
//   CAB_I  consecutive-address burst hint
//   ADR_I  word address (byte address bits 31:2)
//   SEL_I  byte enables, SEL_I[n] qualifies DAT_I[8n+7:8n]
//   DAT_I  write data
//   DAT_O  read data, valid while ACK_O=1 on a read, held otherwise
//   ACK_O  normal termination, one-cycle pulse
//   ERR_O  error termination (address outside window), one-cycle pulse
//
// Timing: a request first sampled at edge S is acknowledged by ACK_O
// registered at edge S+WAIT_CYCLES (S itself for the fast path or for
// WAIT_CYCLES=0). The master therefore sees ACK WAIT_CYCLES+1 cycles after it
// launched the request. ERR_O is registered at S. The edge that closes an
// ACK or ERR cycle never samples a new request.
// -----------------------------------------------------------------------------
module wb_frame_memory #(
  parameter int          ADDR_W      = 10,
  parameter logic [29:0] BASE_WORD   = 30'd0,
  parameter int          WAIT_CYCLES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        CYC_I,
  input  logic        STB_I,
  input  logic        WE_I,
  input  logic        CAB_I,
  input  logic [29:0] ADR_I,
  input  logic [3:0]  SEL_I,
  input  logic [31:0] DAT_I,
  output logic [31:0] DAT_O,
  output logic        ACK_O,
  output logic        ERR_O
);

  localparam int         DEPTH     = 1 << ADDR_W;
  localparam logic [3:0] WAIT_INIT = 4'(WAIT_CYCLES);
  localparam bit         NO_WAIT   = (WAIT_CYCLES == 0);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WAIT,
    ST_RESP
  } state_t;

  state_t      state_reg;
  logic [3:0]  cnt_reg;
  logic [29:0] adr_reg;
  logic        we_reg;
  logic [3:0]  sel_reg;
  logic [31:0] dat_reg;
  logic        burst_reg;
  logic [29:0] last_adr_reg;
  logic        last_we_reg;

  logic              request;
  logic              in_window;
  logic              fast_path;
  logic              start_now;
  logic              finish_wait;
  logic              access;
  logic [29:0]       acc_adr;
  logic              acc_we;
  logic [3:0]        acc_sel;
  logic [31:0]       acc_dat;
  logic [ADDR_W-1:0] acc_idx;
  logic              ram_we;
  logic              ram_re;

  // ---------------------------------------------------------------------------
  // Request decode
  // ---------------------------------------------------------------------------
  always_comb begin
    request   = CYC_I && STB_I;
    // The subtraction wraps, so the lower-bound compare is what rejects
    // addresses just below the window.
    in_window = (ADR_I >= BASE_WORD) && ((ADR_I - BASE_WORD) < 30'(DEPTH));
    fast_path = burst_reg && CAB_I &&
                (ADR_I == last_adr_reg + 30'd1) && (WE_I == last_we_reg);
  end

  // The RAM is touched exactly on the edge that registers ACK_O. A request
  // served straight from IDLE uses the live bus. A request that waited uses
  // the copy captured when it was first sampled.
  always_comb begin
    start_now   = (state_reg == ST_IDLE) && !ERR_O && request && in_window &&
                  (fast_path || NO_WAIT);
    finish_wait = (state_reg == ST_WAIT) && request && (cnt_reg == 4'd1);
    // A reset on the completing edge cancels the access.
    access      = rst && (start_now || finish_wait);

    if (state_reg == ST_WAIT) begin
      acc_adr = adr_reg;
      acc_we  = we_reg;
      acc_sel = sel_reg;
      acc_dat = dat_reg;
    end else begin
      acc_adr = ADR_I;
      acc_we  = WE_I;
      acc_sel = SEL_I;
      acc_dat = DAT_I;
    end

    acc_idx = ADDR_W'(acc_adr - BASE_WORD);
    ram_we  = access && acc_we;
    ram_re  = access && !acc_we;
  end

  // ---------------------------------------------------------------------------
  // Control FSM with registered ACK/ERR
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_reg    <= ST_IDLE;
      cnt_reg      <= 4'd0;
      ACK_O        <= 1'b0;
      ERR_O        <= 1'b0;
      burst_reg    <= 1'b0;
      adr_reg      <= '0;
      we_reg       <= 1'b0;
      sel_reg      <= '0;
      dat_reg      <= '0;
      last_adr_reg <= '0;
      last_we_reg  <= 1'b0;
    end else begin
      ACK_O <= 1'b0;
      ERR_O <= 1'b0;

      case (state_reg)
        ST_IDLE: begin
          // ERR_O high means this edge closes an error cycle: the master is
          // still presenting the failed request, so it is not sampled again.
          if (!ERR_O) begin
            // The burst flag survives only into the very first sampling edge
            // after an ACK. Anything other than a fast-path hit ends the burst.
            burst_reg <= 1'b0;
            if (request) begin
              adr_reg <= ADR_I;
              we_reg  <= WE_I;
              sel_reg <= SEL_I;
              dat_reg <= DAT_I;
              if (!in_window) begin
                ERR_O <= 1'b1;
              end else if (fast_path || NO_WAIT) begin
                ACK_O        <= 1'b1;
                state_reg    <= ST_RESP;
                last_adr_reg <= ADR_I;
                last_we_reg  <= WE_I;
                burst_reg    <= CAB_I;
              end else begin
                state_reg <= ST_WAIT;
                cnt_reg   <= WAIT_INIT;
              end
            end
          end
        end

        ST_WAIT: begin
          if (!request) begin
            // Master gave up: no ACK and no write.
            state_reg <= ST_IDLE;
            cnt_reg   <= 4'd0;
            burst_reg <= 1'b0;
          end else if (cnt_reg == 4'd1) begin
            ACK_O        <= 1'b1;
            state_reg    <= ST_RESP;
            cnt_reg      <= 4'd0;
            last_adr_reg <= adr_reg;
            last_we_reg  <= we_reg;
            burst_reg    <= CAB_I;
          end else begin
            cnt_reg <= cnt_reg - 4'd1;
          end
        end

        ST_RESP: begin
          // ACK cycle. The request seen at this edge is the one being
          // acknowledged, so it is not sampled.
          state_reg <= ST_IDLE;
          if (!CYC_I) begin
            burst_reg <= 1'b0;
          end
        end

        default: begin
          state_reg <= ST_IDLE;
        end
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Frame RAM: one byte-wide array per lane, so each byte enable maps to its
  // own write port. Reads are registered into DAT_O and are updated only on a
  // read ACK. DAT_O therefore holds its value between reads.
  // ---------------------------------------------------------------------------
  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_lane
      logic [7:0] lane_mem [DEPTH];
      logic [7:0] lane_q_reg;

      always_ff @(posedge clk) begin
        if (ram_we && acc_sel[gi]) begin
          lane_mem[acc_idx] <= acc_dat[8*gi +: 8];
        end
      end

      always_ff @(posedge clk) begin
        if (!rst) begin
          lane_q_reg <= 8'h00;
        end else if (ram_re) begin
          lane_q_reg <= lane_mem[acc_idx];
        end
      end

      assign DAT_O[8*gi +: 8] = lane_q_reg;
    end
  endgenerate

endmodule

// File: tb/tb_wb_frame_memory.sv
// -----------------------------------------------------------------------------
// tb_wb_frame_memory
//   Self-checking bench for wb_frame_memory. A word-array reference model
//   predicts read data, byte-merge results, the window check and ACK/ERR
//   latency from the bus rules. Directed scenarios come first: fill, byte
//   merge, window edges, burst latencies, abort and reset in WAIT. Randomized
//   traffic follows.
// -----------------------------------------------------------------------------
module tb_wb_frame_memory;

  localparam int          AW    = 6;
  localparam int          DEPTH = 1 << AW;
  localparam logic [29:0] BASE  = 30'd256;
  localparam int          WAITC = 2;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        cyc = 1'b0;
  logic        stb = 1'b0;
  logic        we  = 1'b0;
  logic        cab = 1'b0;
  logic [29:0] adr = '0;
  logic [3:0]  sel = '0;
  logic [31:0] dat = '0;
  logic [31:0] dat_o;
  logic        ack_o;
  logic        err_o;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model state.
  logic [31:0] ref_mem [DEPTH];
  bit          prev_acked = 1'b0;
  bit          prev_hold  = 1'b0;
  bit          prev_cab   = 1'b0;
  bit          prev_we    = 1'b0;
  logic [29:0] prev_adr   = '0;

  wb_frame_memory #(
    .ADDR_W      (AW),
    .BASE_WORD   (BASE),
    .WAIT_CYCLES (WAITC)
  ) dut (
    .clk   (clk),
    .rst   (rst),
    .CYC_I (cyc),
    .STB_I (stb),
    .WE_I  (we),
    .CAB_I (cab),
    .ADR_I (adr),
    .SEL_I (sel),
    .DAT_I (dat),
    .DAT_O (dat_o),
    .ACK_O (ack_o),
    .ERR_O (err_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Called #1 after a rising edge, which is the edge that launches the
  // request. With hold=1 the bus stays asserted and the next call is
  // back-to-back. Otherwise one idle cycle follows.
  task automatic acc(input logic w, input logic [29:0] a, input logic [3:0] s,
                     input logic [31:0] d, input logic c, input logic hold);
    longint      off;
    bit          inwin;
    bit          fast;
    int          exp_lat;
    int          lat;
    logic        got_ack;
    logic        got_err;
    logic [31:0] exp_d;
    logic [31:0] rd_val;

    off     = longint'(a) - longint'(BASE);
    inwin   = (off >= 0) && (off < DEPTH);
    fast    = inwin && prev_hold && prev_acked && prev_cab && c &&
              (a == prev_adr + 30'd1) && (w == prev_we);
    exp_lat = (!inwin || fast) ? 1 : WAITC + 1;

    cyc = 1'b1; stb = 1'b1; we = w; adr = a; sel = s; dat = d; cab = c;
    lat = 0; got_ack = 1'b0; got_err = 1'b0;
    for (int n = 1; n <= 20; n++) begin
      @(posedge clk); #1;
      if (ack_o || err_o) begin
        lat     = n;
        got_ack = ack_o;
        got_err = err_o;
        break;
      end
    end
    chk("ack", 32'(got_ack), 32'(inwin));
    chk("err", 32'(got_err), 32'(!inwin));
    chk("latency", 32'(lat), 32'(exp_lat));
    rd_val = dat_o;
    if (inwin && !w) begin
      exp_d = ref_mem[int'(off)];
      chk("rdata", dat_o, exp_d);
    end
    if (inwin && w) begin
      for (int b = 0; b < 4; b++) begin
        if (s[b]) ref_mem[int'(off)][8*b +: 8] = d[8*b +: 8];
      end
    end
    $display("txn we=%0d adr=%h sel=%h dat=%h cab=%0d hold=%0d lat=%0d ack=%0d err=%0d dat_o=%h",
             w, a, s, d, c, hold, lat, got_ack, got_err, rd_val);

    // Edge that closes the ACK/ERR cycle: both pulses must be gone.
    @(posedge clk); #1;
    chk("pulse", {30'd0, ack_o, err_o}, 32'd0);
    if (inwin && !w) chk("dat_hold", dat_o, rd_val);

    prev_acked = inwin;
    prev_adr   = a;
    prev_we    = w;
    prev_cab   = c;
    prev_hold  = hold;
    if (!hold) begin
      cyc = 1'b0; stb = 1'b0; cab = 1'b0;
      @(posedge clk); #1;
    end
  endtask

  // Write that the master abandons while the slave is in WAIT.
  task automatic abort_write(input logic [29:0] a, input logic [31:0] d);
    int acks;
    cyc = 1'b1; stb = 1'b1; we = 1'b1; adr = a; sel = 4'hF; dat = d; cab = 1'b0;
    @(posedge clk); #1;
    cyc = 1'b0; stb = 1'b0;
    acks = 0;
    for (int n = 0; n < 5; n++) begin
      @(posedge clk); #1;
      if (ack_o || err_o) acks++;
    end
    chk("abort_no_ack", 32'(acks), 32'd0);
    $display("txn abort adr=%h dat=%h acks=%0d", a, d, acks);
    prev_acked = 1'b0;
    prev_hold  = 1'b0;
  endtask

  // Reset applied on the edge where a waiting write would have completed.
  task automatic reset_in_wait(input logic [29:0] a, input logic [31:0] d);
    cyc = 1'b1; stb = 1'b1; we = 1'b1; adr = a; sel = 4'hF; dat = d; cab = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    chk("rst_ack", 32'(ack_o), 32'd0);
    chk("rst_err", 32'(err_o), 32'd0);
    chk("rst_dat", dat_o, 32'd0);
    $display("txn reset_in_wait adr=%h dat=%h ack=%0d err=%0d dat_o=%h", a, d, ack_o, err_o, dat_o);
    rst = 1'b1; cyc = 1'b0; stb = 1'b0;
    @(posedge clk); #1;
    prev_acked = 1'b0;
    prev_hold  = 1'b0;
  endtask

  initial begin
    logic [29:0] ra;
    int          r;

    repeat (3) @(posedge clk);
    #1;
    chk("reset_ack", 32'(ack_o), 32'd0);
    chk("reset_err", 32'(err_o), 32'd0);
    chk("reset_dat", dat_o, 32'd0);
    rst = 1'b1;
    @(posedge clk); #1;

    // Fill the whole window with one CAB write burst.
    for (int i = 0; i < DEPTH; i++) begin
      acc(1'b1, BASE + 30'(i), 4'hF, $urandom, 1'b1, i < DEPTH - 1);
    end

    // Full-word write and read back, then a single-byte merge.
    acc(1'b1, BASE, 4'hF, 32'hDEADBEEF, 1'b0, 1'b0);
    acc(1'b0, BASE, 4'h0, 32'h0, 1'b0, 1'b0);
    acc(1'b1, BASE, 4'b0010, 32'h0000AA00, 1'b0, 1'b0);
    acc(1'b0, BASE, 4'h0, 32'h0, 1'b0, 1'b0);
    acc(1'b1, BASE + 30'd5, 4'h0, 32'h12345678, 1'b0, 1'b0);
    acc(1'b0, BASE + 30'd5, 4'h0, 32'h0, 1'b0, 1'b0);

    // Window edges, reads and writes.
    acc(1'b0, BASE + 30'(DEPTH), 4'h0, 32'h0, 1'b0, 1'b0);
    acc(1'b0, BASE - 30'd1, 4'h0, 32'h0, 1'b0, 1'b0);
    acc(1'b1, BASE - 30'd1, 4'hF, 32'hFFFFFFFF, 1'b0, 1'b0);
    acc(1'b0, BASE + 30'(DEPTH - 1), 4'h0, 32'h0, 1'b0, 1'b0);
    acc(1'b0, BASE, 4'h0, 32'h0, 1'b0, 1'b0);

    // CAB read burst, then the same burst broken by an idle cycle.
    for (int i = 0; i < 4; i++) acc(1'b0, BASE + 30'(i), 4'h0, 32'h0, 1'b1, i < 3);
    acc(1'b0, BASE + 30'd0, 4'h0, 32'h0, 1'b1, 1'b1);
    acc(1'b0, BASE + 30'd1, 4'h0, 32'h0, 1'b1, 1'b0);
    acc(1'b0, BASE + 30'd2, 4'h0, 32'h0, 1'b1, 1'b0);

    // Abandoned write, then a normal access to the same word.
    abort_write(BASE + 30'd7, 32'hCAFEF00D);
    acc(1'b0, BASE + 30'd7, 4'h0, 32'h0, 1'b0, 1'b0);

    // Reset in WAIT; pre-reset contents must survive.
    reset_in_wait(BASE + 30'd9, 32'h0BADC0DE);
    acc(1'b0, BASE + 30'd9, 4'h0, 32'h0, 1'b0, 1'b0);
    acc(1'b0, BASE, 4'h0, 32'h0, 1'b0, 1'b0);

    // Randomized traffic: sequential runs, WE flips, holes and bad addresses.
    for (int t = 0; t < 200; t++) begin
      r = int'($urandom_range(0, 9));
      if (r == 0) begin
        ra = ($urandom_range(0, 1) == 1) ? BASE - 30'($urandom_range(1, 20))
                                         : BASE + 30'(DEPTH) + 30'($urandom_range(0, 100));
      end else if (r <= 4) begin
        ra = prev_adr + 30'd1;
      end else begin
        ra = BASE + 30'($urandom_range(0, DEPTH - 1));
      end
      acc(1'($urandom_range(0, 3) == 0 ? ~prev_we : prev_we), ra, 4'($urandom),
          $urandom, 1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 2) != 0));
    end
    cyc = 1'b0; stb = 1'b0;
    @(posedge clk); #1;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
    $fatal(1);
  end

endmodule
